limber_gnrl_fifo_sync_v2: RTL and testbench



---
 rtl/limber_gnrl_fifo_sync_v2_if.sv | 31 +++
 rtl/limber_gnrl_fifo_sync_v2.sv | 121 ++++++++++++
 tb/tb_limber_gnrl_fifo_sync_v2.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/limber_gnrl_fifo_sync_v2_if.sv
// Handshake/data bundle between a FIFO user and limber_gnrl_fifo_sync_v2.
interface limber_gnrl_fifo_sync_v2_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4
);
  logic [DW-1:0] din;
  logic          wen;
  logic          ren;
  logic          err_clr;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          empty;
  logic          full;
  logic          almost_empty;
  logic          almost_full;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  modport master (
    output din, wen, ren, err_clr,
    input  dout, dout_vld, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );

  modport slave (
    input  din, wen, ren, err_clr,
    output dout, dout_vld, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );
endinterface

// File: rtl/limber_gnrl_fifo_sync_v2.sv
// Synchronous FIFO using all 2^AW entries (wrap-bit pointers), with occupancy
// count, almost thresholds, sticky error flags and FWFT/registered read modes.
module limber_gnrl_fifo_sync_v2 #(
  parameter int unsigned DW           = 8,
  parameter int unsigned AW           = 4,
  parameter int unsigned FWFT         = 0,
  parameter int unsigned AFULL_TH     = (1 << AW) - 2,
  parameter int unsigned AEMPTY_TH    = 1,
  parameter int unsigned FORCE_X2ZERO = 0
) (
  input logic                      clk,
  input logic                      rst,
  limber_gnrl_fifo_sync_v2_if.slave fifo_if
);

  localparam int unsigned DP = 1 << AW;
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem [DP];

  logic [CW-1:0] wptr_q, rptr_q, count_q;
  logic [CW-1:0] wptr_nxt, rptr_nxt, count_nxt;
  logic          empty_q, full_q, aempty_q, afull_q;
  logic          overflow_q, underflow_q;
  logic          wr_acc, rd_acc;
  logic          empty_nxt, full_nxt;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] rd_data;
  logic          rd_vld;

  // Acceptance on pre-edge flags and next-state pointer/count arithmetic
  always_comb begin
    wr_acc    = fifo_if.wen & ~full_q;
    rd_acc    = fifo_if.ren & ~empty_q;
    waddr     = wptr_q[AW-1:0];
    raddr     = rptr_q[AW-1:0];
    wptr_nxt  = wptr_q + CW'(wr_acc);
    rptr_nxt  = rptr_q + CW'(rd_acc);
    count_nxt = count_q + CW'(wr_acc) - CW'(rd_acc);
    empty_nxt = (wptr_nxt == rptr_nxt);
    full_nxt  = (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]) &&
                (wptr_nxt[AW] != rptr_nxt[AW]);
  end

  // Pointers, occupancy and status flags, all registered so they are glitch-free
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      aempty_q    <= 1'b1;
      afull_q     <= 1'(AFULL_TH == 0);
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_nxt;
      rptr_q      <= rptr_nxt;
      count_q     <= count_nxt;
      empty_q     <= empty_nxt;
      full_q      <= full_nxt;
      aempty_q    <= (count_nxt <= CW'(AEMPTY_TH));
      afull_q     <= (count_nxt >= CW'(AFULL_TH));
      overflow_q  <= (fifo_if.wen & full_q)  | (overflow_q  & ~fifo_if.err_clr);
      underflow_q <= (fifo_if.ren & empty_q) | (underflow_q & ~fifo_if.err_clr);
    end
  end

  // Storage array; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[waddr] <= fifo_if.din;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is presented combinationally whenever the FIFO holds data
      always_comb begin
        rd_data = mem[raddr];
        rd_vld  = ~empty_q;
      end
    end else begin : g_reg
      logic [DW-1:0] dout_q;
      logic          dout_vld_q;

      // Registered read: data lands one cycle after an accepted ren
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          dout_q     <= '0;
          dout_vld_q <= 1'b0;
        end else begin
          dout_vld_q <= rd_acc;
          if (rd_acc) begin
            dout_q <= mem[raddr];
          end
        end
      end

      always_comb begin
        rd_data = dout_q;
        rd_vld  = dout_vld_q;
      end
    end
  endgenerate

  // Output drive, optionally masking invalid data to zero
  always_comb begin
    fifo_if.dout         = ((FORCE_X2ZERO != 0) && !rd_vld) ? '0 : rd_data;
    fifo_if.dout_vld     = rd_vld;
    fifo_if.empty        = empty_q;
    fifo_if.full         = full_q;
    fifo_if.almost_empty = aempty_q;
    fifo_if.almost_full  = afull_q;
    fifo_if.count        = count_q;
    fifo_if.overflow     = overflow_q;
    fifo_if.underflow    = underflow_q;
  end

endmodule

// File: tb/tb_limber_gnrl_fifo_sync_v2.sv
// Bench for limber_gnrl_fifo_sync_v2: registered-read 16-deep instance plus a
// 4-deep FWFT instance with zero-forced dout.
module tb_limber_gnrl_fifo_sync_v2;

  localparam int unsigned DP0 = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  limber_gnrl_fifo_sync_v2_if #(.DW(8), .AW(4)) f0 ();
  limber_gnrl_fifo_sync_v2_if #(.DW(8), .AW(2)) f1 ();

  limber_gnrl_fifo_sync_v2 #(
    .DW(8), .AW(4), .FWFT(0), .AFULL_TH(14), .AEMPTY_TH(1), .FORCE_X2ZERO(0)
  ) u_dut0 (
    .clk    (clk),
    .rst    (rst),
    .fifo_if(f0)
  );

  limber_gnrl_fifo_sync_v2 #(
    .DW(8), .AW(2), .FWFT(1), .AFULL_TH(2), .AEMPTY_TH(1), .FORCE_X2ZERO(1)
  ) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .fifo_if(f1)
  );

  int total = 0;
  int bad   = 0;

  // Reference model for dut0
  logic [7:0] q[$];
  logic       m_ovf  = 1'b0;
  logic       m_udf  = 1'b0;
  logic       m_vld  = 1'b0;
  logic [7:0] m_dout = 8'h00;
  int         pushes = 0;

  typedef struct {
    logic       w, r, c;
    logic [7:0] din;
    int         cnt;
    logic       emp, ful, ae, af, ovf, udf, vld;
    logic [7:0] dout;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=0x%0h exp=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic w, r, c, input logic [7:0] d, input int cnt,
                              input logic emp, ful, ae, af, ovf, udf, vld,
                              input logic [7:0] dout);
    vec_t v;
    v.w = w; v.r = r; v.c = c; v.din = d; v.cnt = cnt;
    v.emp = emp; v.ful = ful; v.ae = ae; v.af = af;
    v.ovf = ovf; v.udf = udf; v.vld = vld; v.dout = dout;
    vt.push_back(v);
  endfunction

  // One clock of dut0 stimulus; the model advances on pre-edge state
  task automatic step0(input logic w, r, c, input logic [7:0] d);
    logic was_full, was_empty;
    @(negedge clk);
    f0.wen = w; f0.ren = r; f0.err_clr = c; f0.din = d;
    @(posedge clk);
    #1;
    was_full  = (q.size() == DP0);
    was_empty = (q.size() == 0);
    m_ovf = (w & was_full)  | (m_ovf & ~c);
    m_udf = (r & was_empty) | (m_udf & ~c);
    if (r && !was_empty) begin
      m_dout = q.pop_front();
      m_vld  = 1'b1;
    end else begin
      m_vld = 1'b0;
    end
    if (w && !was_full) begin
      q.push_back(d);
      pushes++;
    end
    f0.wen = 1'b0; f0.ren = 1'b0; f0.err_clr = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 32'(f0.count), 32'(n));
    chk({tag, ".empty"}, 32'(f0.empty), 32'(n == 0));
    chk({tag, ".full"},  32'(f0.full),  32'(n == DP0));
    chk({tag, ".aempty"}, 32'(f0.almost_empty), 32'(n <= 1));
    chk({tag, ".afull"}, 32'(f0.almost_full), 32'(n >= 14));
    chk({tag, ".ovf"},   32'(f0.overflow),  32'(m_ovf));
    chk({tag, ".udf"},   32'(f0.underflow), 32'(m_udf));
    chk({tag, ".vld"},   32'(f0.dout_vld),  32'(m_vld));
    chk({tag, ".dout"},  32'(f0.dout),      32'(m_dout));
  endtask

  task automatic step1(input logic w, r, input logic [7:0] d);
    @(negedge clk);
    f1.wen = w; f1.ren = r; f1.din = d;
    @(posedge clk);
    #1;
    f1.wen = 1'b0; f1.ren = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    f0.wen = 1'b0; f0.ren = 1'b0; f0.err_clr = 1'b0; f0.din = 8'h00;
    f1.wen = 1'b0; f1.ren = 1'b0; f1.err_clr = 1'b0; f1.din = 8'h00;

    // Fill, overflow, drain, error-flag and simultaneous-on-empty vectors
    for (int i = 0; i < 16; i++)
      add(1, 0, 0, 8'(i), i + 1, 0, (i == 15), ((i + 1) <= 1), ((i + 1) >= 14), 0, 0, 0, 8'h00);
    add(1, 0, 0, 8'hAA, 16, 0, 1, 0, 1, 1, 0, 0, 8'h00);
    for (int j = 0; j < 16; j++)
      add(0, 1, 0, 8'h00, 15 - j, (j == 15), 0, ((15 - j) <= 1), ((15 - j) >= 14), 1, 0, 1, 8'(j));
    add(0, 0, 0, 8'h00, 0, 1, 0, 1, 0, 1, 0, 0, 8'h0F);
    add(0, 1, 0, 8'h00, 0, 1, 0, 1, 0, 1, 1, 0, 8'h0F);
    add(0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 0, 0, 0, 8'h0F);
    add(0, 1, 1, 8'h00, 0, 1, 0, 1, 0, 0, 1, 0, 8'h0F);
    add(0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 0, 0, 0, 8'h0F);
    add(1, 1, 0, 8'h33, 1, 0, 0, 1, 0, 0, 1, 0, 8'h0F);
    add(0, 0, 1, 8'h00, 1, 0, 0, 1, 0, 0, 0, 0, 8'h0F);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.count", 32'(f0.count), 32'd0);
    chk("rst.empty", 32'(f0.empty), 32'd1);
    chk("rst.full",  32'(f0.full),  32'd0);
    chk("rst.aempty", 32'(f0.almost_empty), 32'd1);
    chk("rst.afull", 32'(f0.almost_full), 32'd0);
    chk("rst.vld",   32'(f0.dout_vld), 32'd0);
    chk("rst.dout",  32'(f0.dout), 32'd0);
    chk("rst1.dout", 32'(f1.dout), 32'd0);
    chk("rst1.vld",  32'(f1.dout_vld), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven directed vectors
    for (int k = 0; k < vt.size(); k++) begin
      step0(vt[k].w, vt[k].r, vt[k].c, vt[k].din);
      chk($sformatf("vec%0d.count", k), 32'(f0.count), 32'(vt[k].cnt));
      chk($sformatf("vec%0d.empty", k), 32'(f0.empty), 32'(vt[k].emp));
      chk($sformatf("vec%0d.full", k),  32'(f0.full),  32'(vt[k].ful));
      chk($sformatf("vec%0d.aempty", k), 32'(f0.almost_empty), 32'(vt[k].ae));
      chk($sformatf("vec%0d.afull", k), 32'(f0.almost_full), 32'(vt[k].af));
      chk($sformatf("vec%0d.ovf", k),   32'(f0.overflow),  32'(vt[k].ovf));
      chk($sformatf("vec%0d.udf", k),   32'(f0.underflow), 32'(vt[k].udf));
      chk($sformatf("vec%0d.vld", k),   32'(f0.dout_vld),  32'(vt[k].vld));
      chk($sformatf("vec%0d.dout", k),  32'(f0.dout),      32'(vt[k].dout));
    end

    // Simultaneous read/write at count 8 keeps count and order
    for (int i = 0; i < 7; i++) step0(1, 0, 0, 8'(8'h40 + i));
    check_model("mid8");
    for (int i = 0; i < 20; i++) begin
      step0(1, 1, 0, 8'(8'h50 + i));
      chk($sformatf("rw8.count%0d", i), 32'(f0.count), 32'd8);
      check_model($sformatf("rw8_%0d", i));
    end

    // Simultaneous read/write when full: write dropped, count 15
    for (int i = 0; i < 8; i++) step0(1, 0, 0, 8'(8'h70 + i));
    chk("full16.full", 32'(f0.full), 32'd1);
    step0(1, 1, 0, 8'hEE);
    chk("fullrw.count", 32'(f0.count), 32'd15);
    chk("fullrw.ovf", 32'(f0.overflow), 32'd1);
    check_model("fullrw");
    for (int i = 0; i < 15; i++) begin
      step0(0, 1, 0, 8'h00);
      check_model($sformatf("drain%0d", i));
    end
    step0(0, 0, 1, 8'h00);
    check_model("clr2");

    // Random traffic with alternating fill/drain bias to wrap the pointers
    for (int k = 0; k < 300; k++) begin
      logic w, r, c;
      if (((k / 25) % 2) == 0) begin
        w = ($urandom_range(0, 99) < 75);
        r = ($urandom_range(0, 99) < 30);
      end else begin
        w = ($urandom_range(0, 99) < 30);
        r = ($urandom_range(0, 99) < 75);
      end
      c = ($urandom_range(0, 99) < 5);
      step0(w, r, c, 8'($urandom_range(0, 255)));
      check_model($sformatf("rnd%0d", k));
    end
    chk("rnd.wraps", 32'(pushes >= 3 * 32), 32'd1);

    // Async reset asserted between clock edges in the middle of a burst
    step0(1, 0, 0, 8'h91);
    step0(1, 0, 0, 8'h92);
    @(negedge clk);
    f0.wen = 1'b1; f0.ren = 1'b1; f0.din = 8'h93;
    @(posedge clk);
    #1;
    chk("pre_rst.vld", 32'(f0.dout_vld), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst.count", 32'(f0.count), 32'd0);
    chk("arst.empty", 32'(f0.empty), 32'd1);
    chk("arst.full",  32'(f0.full),  32'd0);
    chk("arst.aempty", 32'(f0.almost_empty), 32'd1);
    chk("arst.ovf",   32'(f0.overflow), 32'd0);
    chk("arst.vld",   32'(f0.dout_vld), 32'd0);
    chk("arst.dout",  32'(f0.dout), 32'd0);
    f0.wen = 1'b0; f0.ren = 1'b0;
    q.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_vld = 1'b0; m_dout = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    step0(1, 0, 0, 8'h77);
    step0(0, 1, 0, 8'h00);
    chk("post_rst.dout", 32'(f0.dout), 32'h77);
    check_model("post_rst");

    // FWFT instance: data visible the cycle after the write, no ren needed
    chk("fw.empty0", 32'(f1.empty), 32'd1);
    chk("fw.dout0",  32'(f1.dout), 32'd0);
    step1(1, 0, 8'h5A);
    chk("fw.dout1",  32'(f1.dout), 32'h5A);
    chk("fw.vld1",   32'(f1.dout_vld), 32'd1);
    chk("fw.count1", 32'(f1.count), 32'd1);
    step1(1, 0, 8'h6B);
    chk("fw.dout2",  32'(f1.dout), 32'h5A);
    chk("fw.count2", 32'(f1.count), 32'd2);
    chk("fw.afull2", 32'(f1.almost_full), 32'd1);
    chk("fw.aempty2", 32'(f1.almost_empty), 32'd0);
    step1(0, 1, 8'h00);
    chk("fw.dout3",  32'(f1.dout), 32'h6B);
    chk("fw.vld3",   32'(f1.dout_vld), 32'd1);
    chk("fw.afull3", 32'(f1.almost_full), 32'd0);
    step1(0, 1, 8'h00);
    chk("fw.empty4", 32'(f1.empty), 32'd1);
    chk("fw.vld4",   32'(f1.dout_vld), 32'd0);
    chk("fw.dout4",  32'(f1.dout), 32'd0);
    step1(0, 1, 8'h00);
    chk("fw.udf5",   32'(f1.underflow), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
